// File: rtl/reservation_station_pkg.sv
// Shared types for the Tomasulo issue path: control word, ALU dispatch word,
// CDB broadcast record and the ROB tag width.
package tomasula_types;

    localparam int unsigned TAG_W = 3;
    localparam int unsigned CDB_N = 8;

    typedef struct packed {
        logic [2:0]       op;
        logic             funct7;
        logic [TAG_W-1:0] rd_tag;
    } ctl_word;

    typedef struct packed {
        logic [2:0]       op;
        logic             funct7;
        logic [31:0]      vj;
        logic [31:0]      vk;
        logic [TAG_W-1:0] tag;
    } alu_word;

    typedef struct packed {
        logic [31:0] data;
        logic        request;
    } cdb_data;

endpackage

// File: rtl/reservation_station_entry.sv
// One reservation-station slot: captures an issued op, snoops the CDB for
// missing operands and reports when both operands are final.
module rs_entry
    import tomasula_types::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             alloc,
    input  logic             dispatch,
    input  ctl_word          control_i,
    input  logic [31:0]      src1_data,
    input  logic [31:0]      src2_data,
    input  logic             src1_valid,
    input  logic             src2_valid,
    input  logic [TAG_W-1:0] tag_a,
    input  logic [TAG_W-1:0] tag_b,
    input  cdb_data          cdb_in [CDB_N],
    output logic             busy,
    output logic             ready,
    output alu_word          entry_word
);

    ctl_word          ctl;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
    logic             vj_ok;
    logic             vk_ok;

    // Slot state: flush beats allocate, allocate beats wakeup/dispatch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy  <= 1'b0;
            ctl   <= '0;
            vj    <= '0;
            vk    <= '0;
            qj    <= '0;
            qk    <= '0;
            vj_ok <= 1'b0;
            vk_ok <= 1'b0;
        end else if (flush) begin
            busy <= 1'b0;
        end else if (alloc) begin
            busy <= 1'b1;
            ctl  <= control_i;
            qj   <= tag_a;
            qk   <= tag_b;
            // operand j: regfile value, same-cycle CDB bypass, or wait on tag
            if (src1_valid) begin
                vj    <= src1_data;
                vj_ok <= 1'b1;
            end else if (cdb_in[tag_a].request) begin
                vj    <= cdb_in[tag_a].data;
                vj_ok <= 1'b1;
            end else begin
                vj_ok <= 1'b0;
            end
            if (src2_valid) begin
                vk    <= src2_data;
                vk_ok <= 1'b1;
            end else if (cdb_in[tag_b].request) begin
                vk    <= cdb_in[tag_b].data;
                vk_ok <= 1'b1;
            end else begin
                vk_ok <= 1'b0;
            end
        end else begin
            if (dispatch) begin
                busy <= 1'b0;
            end
            if (busy && !vj_ok && cdb_in[qj].request) begin
                vj    <= cdb_in[qj].data;
                vj_ok <= 1'b1;
            end
            if (busy && !vk_ok && cdb_in[qk].request) begin
                vk    <= cdb_in[qk].data;
                vk_ok <= 1'b1;
            end
        end
    end

    assign ready      = busy && vj_ok && vk_ok;
    assign entry_word = '{op: ctl.op, funct7: ctl.funct7, vj: vj, vk: vk, tag: ctl.rd_tag};

endmodule

// File: rtl/reservation_station.sv
// Reservation station: DEPTH slots, lowest-free allocation, lowest-ready
// dispatch to a single ALU with a valid/ready style handshake.
module reservation_station
    import tomasula_types::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             res_load,
    input  ctl_word          control_i,
    input  logic [31:0]      src1_data,
    input  logic [31:0]      src2_data,
    input  logic             src1_valid,
    input  logic             src2_valid,
    input  logic [TAG_W-1:0] tag_a,
    input  logic [TAG_W-1:0] tag_b,
    input  cdb_data          cdb_in [CDB_N],
    input  logic             flush,
    input  logic             alu_ready,
    output logic             res_empty,
    output logic             res_exec,
    output alu_word          res_alu_out
);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] free;
    logic [DEPTH-1:0] alloc_sel;
    logic [DEPTH-1:0] pick_sel;
    logic [DEPTH-1:0] disp_sel;
    alu_word          words    [DEPTH];
    alu_word          or_chain [DEPTH+1];

    // x & -x isolates the lowest set bit: a one-hot priority pick
    assign free      = ~busy;
    assign alloc_sel = (res_load && !flush) ? (free & (~free + DEPTH'(1))) : '0;
    assign pick_sel  = ready & (~ready + DEPTH'(1));

    assign res_empty = |free;
    assign res_exec  = (|ready) && !flush;
    assign disp_sel  = (res_exec && alu_ready) ? pick_sel : '0;

    assign or_chain[0] = '0;

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_slot
            rs_entry u_entry (
                .clk        (clk),
                .reset_n    (reset_n),
                .flush      (flush),
                .alloc      (alloc_sel[g]),
                .dispatch   (disp_sel[g]),
                .control_i  (control_i),
                .src1_data  (src1_data),
                .src2_data  (src2_data),
                .src1_valid (src1_valid),
                .src2_valid (src2_valid),
                .tag_a      (tag_a),
                .tag_b      (tag_b),
                .cdb_in     (cdb_in),
                .busy       (busy[g]),
                .ready      (ready[g]),
                .entry_word (words[g])
            );
            assign or_chain[g+1] = or_chain[g] | (pick_sel[g] ? words[g] : '0);
        end
    endgenerate

    assign res_alu_out = res_exec ? or_chain[DEPTH] : '0;

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: directed vector table, an
// asynchronous reset check and randomized traffic against an array model.
module tb_reservation_station;
    import tomasula_types::*;

    localparam int D = 2;

    logic          clk;
    logic          reset_n;
    logic          res_load;
    ctl_word       control_i;
    logic [31:0]   src1_data, src2_data;
    logic          src1_valid, src2_valid;
    logic [2:0]    tag_a, tag_b;
    cdb_data       cdb [8];
    logic          flush;
    logic          alu_ready;
    logic          res_empty;
    logic          res_exec;
    alu_word       res_alu_out;

    int passed = 0;
    int total  = 0;

    reservation_station #(.DEPTH(D)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .res_load    (res_load),
        .control_i   (control_i),
        .src1_data   (src1_data),
        .src2_data   (src2_data),
        .src1_valid  (src1_valid),
        .src2_valid  (src2_valid),
        .tag_a       (tag_a),
        .tag_b       (tag_b),
        .cdb_in      (cdb),
        .flush       (flush),
        .alu_ready   (alu_ready),
        .res_empty   (res_empty),
        .res_exec    (res_exec),
        .res_alu_out (res_alu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model: a list of pending ops ----------------
    bit          m_busy [D];
    logic [2:0]  m_op   [D];
    bit          m_f7   [D];
    logic [2:0]  m_rd   [D];
    logic [31:0] m_vj   [D];
    logic [31:0] m_vk   [D];
    logic [2:0]  m_qj   [D];
    logic [2:0]  m_qk   [D];
    bit          m_okj  [D];
    bit          m_okk  [D];

    function automatic int m_pick();
        for (int i = 0; i < D; i++)
            if (m_busy[i] && m_okj[i] && m_okk[i]) return i;
        return -1;
    endfunction

    function automatic int m_free();
        for (int i = 0; i < D; i++)
            if (!m_busy[i]) return i;
        return -1;
    endfunction

    function automatic logic [70:0] aw(input logic [2:0] op, input bit f7,
                                       input logic [31:0] vj, input logic [31:0] vk,
                                       input logic [2:0] tag);
        return {op, f7, vj, vk, tag};
    endfunction

    function automatic logic [6:0] cw(input logic [2:0] op, input bit f7, input logic [2:0] rd);
        return {op, f7, rd};
    endfunction

    function automatic bit exp_empty();
        return m_free() >= 0;
    endfunction

    function automatic bit exp_exec();
        return (m_pick() >= 0) && !flush;
    endfunction

    function automatic logic [70:0] exp_out();
        int p;
        p = m_pick();
        if (p < 0 || flush) return '0;
        return aw(m_op[p], m_f7[p], m_vj[p], m_vk[p], m_rd[p]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < D; i++) begin
            m_busy[i] = 0;
            m_okj[i]  = 0;
            m_okk[i]  = 0;
        end
    endtask

    // advance the model by one clock edge using the inputs currently driven
    task automatic model_edge();
        int p, f;
        if (flush) begin
            for (int i = 0; i < D; i++) m_busy[i] = 0;
            return;
        end
        p = m_pick();
        f = m_free();
        for (int i = 0; i < D; i++) begin
            if (m_busy[i] && !m_okj[i] && cdb[m_qj[i]].request) begin
                m_vj[i] = cdb[m_qj[i]].data; m_okj[i] = 1;
            end
            if (m_busy[i] && !m_okk[i] && cdb[m_qk[i]].request) begin
                m_vk[i] = cdb[m_qk[i]].data; m_okk[i] = 1;
            end
        end
        if (p >= 0 && alu_ready) m_busy[p] = 0;
        if (res_load && f >= 0) begin
            m_busy[f] = 1;
            m_op[f] = control_i.op;
            m_f7[f] = control_i.funct7;
            m_rd[f] = control_i.rd_tag;
            m_qj[f] = tag_a;
            m_qk[f] = tag_b;
            if (src1_valid) begin m_vj[f] = src1_data; m_okj[f] = 1; end
            else if (cdb[tag_a].request) begin m_vj[f] = cdb[tag_a].data; m_okj[f] = 1; end
            else m_okj[f] = 0;
            if (src2_valid) begin m_vk[f] = src2_data; m_okk[f] = 1; end
            else if (cdb[tag_b].request) begin m_vk[f] = cdb[tag_b].data; m_okk[f] = 1; end
            else m_okk[f] = 0;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [70:0] act, input logic [70:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    endtask

    task automatic idle_inputs();
        res_load = 0; control_i = '0;
        src1_data = '0; src2_data = '0; src1_valid = 0; src2_valid = 0;
        tag_a = '0; tag_b = '0; flush = 0; alu_ready = 0;
        for (int i = 0; i < 8; i++) cdb[i] = '0;
    endtask

    task automatic check_model(input string pfx);
        chk({pfx, "_empty"}, 71'(res_empty), 71'(exp_empty()));
        chk({pfx, "_exec"},  71'(res_exec),  71'(exp_exec()));
        chk({pfx, "_out"},   res_alu_out,    exp_out());
    endtask

    // inputs already driven; sample, then take one clock edge
    task automatic step_model(input string pfx);
        #1;
        check_model(pfx);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          load;
        logic [6:0]  ctl;
        logic [31:0] s1, s2;
        bit          v1, v2;
        logic [2:0]  ta, tb;
        bit          creq;
        logic [2:0]  ctag;
        logic [31:0] cdata;
        bit          fl, ar;
        bit          e_empty, e_exec;
        logic [70:0] e_out;
    } vec_t;

    vec_t vt [16];

    function automatic vec_t mk(input bit load, input logic [6:0] ctl,
                                input logic [31:0] s1, input logic [31:0] s2,
                                input bit v1, input bit v2,
                                input logic [2:0] ta, input logic [2:0] tb,
                                input bit creq, input logic [2:0] ctag, input logic [31:0] cdata,
                                input bit fl, input bit ar,
                                input bit e_empty, input bit e_exec, input logic [70:0] e_out);
        vec_t v;
        v.load = load; v.ctl = ctl; v.s1 = s1; v.s2 = s2; v.v1 = v1; v.v2 = v2;
        v.ta = ta; v.tb = tb; v.creq = creq; v.ctag = ctag; v.cdata = cdata;
        v.fl = fl; v.ar = ar; v.e_empty = e_empty; v.e_exec = e_exec; v.e_out = e_out;
        return v;
    endfunction

    initial begin
        logic [70:0] held;
        idle_inputs();
        model_reset();
        reset_n = 0;
        #2;
        chk("reset_empty", 71'(res_empty), 71'(1'b1));
        chk("reset_exec",  71'(res_exec),  71'(1'b0));
        chk("reset_out",   res_alu_out,    '0);
        @(negedge clk); @(negedge clk);
        reset_n = 1;

        // ADD 5+7 -> tag 3, dispatch, then wakeup of vk via CDB tag 6,
        // fill to full with ignored third load, bypass capture, flush with load
        vt[0]  = mk(1, cw(0,0,3), 5, 7, 1, 1, 0, 0,  0, 0, 0,         0, 0,  1, 0, '0);
        vt[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0,         0, 1,  1, 1, aw(0,0,5,7,3));
        vt[2]  = mk(1, cw(1,1,4), 9, 32'hdead, 1, 0, 0, 6, 0, 0, 0,   0, 1,  1, 0, '0);
        vt[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0,         0, 1,  1, 0, '0);
        vt[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0,         0, 1,  1, 0, '0);
        vt[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0,          1, 6, 32'h1234,  0, 0,  1, 0, '0);
        vt[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0,         0, 0,  1, 1, aw(1,1,9,32'h1234,4));
        vt[7]  = mk(1, cw(2,0,5), 1, 2, 1, 1, 0, 0,  0, 0, 0,         0, 0,  1, 1, aw(1,1,9,32'h1234,4));
        vt[8]  = mk(1, cw(3,0,6), 3, 4, 1, 1, 0, 0,  0, 0, 0,         0, 0,  0, 1, aw(1,1,9,32'h1234,4));
        vt[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0,         0, 1,  0, 1, aw(1,1,9,32'h1234,4));
        vt[10] = mk(0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0,         0, 0,  1, 1, aw(2,0,1,2,5));
        vt[11] = mk(1, cw(4,0,7), 32'hbad, 8, 0, 1, 2, 0, 1, 2, 32'hab, 0, 1, 1, 1, aw(2,0,1,2,5));
        vt[12] = mk(0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0,         0, 0,  1, 1, aw(4,0,32'hab,8,7));
        vt[13] = mk(1, cw(5,0,1), 32'h11, 32'h22, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, aw(4,0,32'hab,8,7));
        vt[14] = mk(1, cw(6,0,2), 1, 1, 1, 1, 0, 0,  0, 0, 0,         1, 1,  0, 0, '0);
        vt[15] = mk(0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0,         0, 0,  1, 0, '0);

        for (int i = 0; i < 16; i++) begin
            idle_inputs();
            res_load = vt[i].load; control_i = vt[i].ctl;
            src1_data = vt[i].s1; src2_data = vt[i].s2;
            src1_valid = vt[i].v1; src2_valid = vt[i].v2;
            tag_a = vt[i].ta; tag_b = vt[i].tb;
            if (vt[i].creq) cdb[vt[i].ctag] = '{data: vt[i].cdata, request: 1'b1};
            flush = vt[i].fl; alu_ready = vt[i].ar;
            #1;
            chk($sformatf("vec%0d_empty", i), 71'(res_empty), 71'(vt[i].e_empty));
            chk($sformatf("vec%0d_exec", i),  71'(res_exec),  71'(vt[i].e_exec));
            chk($sformatf("vec%0d_out", i),   res_alu_out,    vt[i].e_out);
            @(posedge clk);
            model_edge();
            @(negedge clk);
        end

        // two busy entries, then an asynchronous reset between clock edges
        idle_inputs();
        res_load = 1; control_i = cw(1,0,2); src1_data = 32'h10; src2_data = 32'h20;
        src1_valid = 1; src2_valid = 1;
        step_model("preload0");
        control_i = cw(2,1,3); src1_data = 32'h30; src2_valid = 0; tag_b = 5;
        step_model("preload1");
        idle_inputs();
        #1;
        chk("full_before_reset", 71'(res_empty), 71'(1'b0));
        held = res_alu_out;
        #1;
        reset_n = 0;
        #1;
        chk("async_reset_empty", 71'(res_empty), 71'(1'b1));
        chk("async_reset_exec",  71'(res_exec),  71'(1'b0));
        chk("async_reset_out",   res_alu_out,    '0);
        chk("held_out_before_reset", held, aw(1,0,32'h10,32'h20,2));
        model_reset();
        @(negedge clk);
        reset_n = 1;

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            idle_inputs();
            res_load   = ($urandom_range(0, 9) < 6);
            control_i  = 7'($urandom);
            src1_data  = $urandom;
            src2_data  = $urandom;
            src1_valid = $urandom_range(0, 1) == 1;
            src2_valid = $urandom_range(0, 1) == 1;
            tag_a      = 3'($urandom);
            tag_b      = 3'($urandom);
            for (int t = 0; t < 8; t++)
                if ($urandom_range(0, 4) == 0) cdb[t] = '{data: $urandom, request: 1'b1};
            flush     = ($urandom_range(0, 15) == 0);
            alu_ready = $urandom_range(0, 2) != 0;
            step_model("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
